// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1-style serial transmitter fed from the TX FIFO
//
// Pops bytes from the TX FIFO and shifts each one out as a frame: a start bit,
// D_W data bits sent LSB first, then a stop period. The module generates its own
// oversampling baud tick from a 16-bit divisor.
//
// Parameters:
//   D_W      data bits per frame
//   B_TICK   baud ticks per start/data bit
//   SB_TICK  baud ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   brg         baud divisor; one tick every brg+1 clocks, latched per frame
//   en          transmit enable; gates new FIFO pops only
//   fifo_data   TX FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty  TX FIFO empty flag
//   fifo_rd_en  one-cycle FIFO pop strobe
//   tx          serial line, idle high, registered
//   busy        high in every state except IDLE
//   tx_done     one-cycle pulse on the return to IDLE
module uart_tx #(
    parameter int D_W     = 8,
    parameter int B_TICK  = 16,
    parameter int SB_TICK = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    brg,
    input  logic           en,
    input  logic [D_W-1:0] fifo_data,
    input  logic           fifo_empty,
    output logic           fifo_rd_en,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);

    localparam int T_MAX = (B_TICK > SB_TICK) ? B_TICK : SB_TICK;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int BW    = $clog2(D_W) + 1;

    localparam logic [TW-1:0] B_LAST  = TW'(B_TICK - 1);
    localparam logic [TW-1:0] SB_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] D_LAST  = BW'(D_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state, state_n;
    logic [15:0]    div_cnt, div_n;
    logic [15:0]    brg_q, brg_n;
    logic [TW-1:0]  tick_cnt, tick_n;
    logic [BW-1:0]  bit_idx, bit_n;
    logic [D_W-1:0] sr, sr_n;
    logic           tx_q, tx_n;
    logic           done_q, done_n;
    logic           tick;

    // Divider runs against the per-frame copy of the divisor so a brg write
    // mid-frame cannot stretch or shrink the bit currently on the wire.
    assign tick = (div_cnt == brg_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            brg_q    <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            sr       <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            brg_q    <= brg_n;
            tick_cnt <= tick_n;
            bit_idx  <= bit_n;
            sr       <= sr_n;
            tx_q     <= tx_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_n      = div_cnt;
        brg_n      = brg_q;
        tick_n     = tick_cnt;
        bit_n      = bit_idx;
        sr_n       = sr;
        done_n     = 1'b0;
        fifo_rd_en = 1'b0;

        case (state)
            IDLE: begin
                div_n  = '0;
                tick_n = '0;
                bit_n  = '0;
                // Gated by rst so the FIFO is never popped while held in reset.
                fifo_rd_en = rst & en & ~fifo_empty;
                if (fifo_rd_en) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                sr_n    = fifo_data;
                brg_n   = brg;
                div_n   = '0;
                tick_n  = '0;
                state_n = START;
            end
            START: begin
                div_n = tick ? 16'd0 : div_cnt + 16'd1;
                if (tick) begin
                    if (tick_cnt == B_LAST) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = DATA;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                div_n = tick ? 16'd0 : div_cnt + 16'd1;
                if (tick) begin
                    if (tick_cnt == B_LAST) begin
                        tick_n = '0;
                        sr_n   = {1'b0, sr[D_W-1:1]};
                        if (bit_idx == D_LAST) begin
                            bit_n   = '0;
                            state_n = STOP;
                        end else begin
                            bit_n = bit_idx + BW'(1);
                        end
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                div_n = tick ? 16'd0 : div_cnt + 16'd1;
                if (tick) begin
                    if (tick_cnt == SB_LAST) begin
                        tick_n  = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // tx is decoded from the next state and registered, so the line only
        // changes on a clock edge and lines up with the state it belongs to.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sr_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign busy    = (state != IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] brg;
    logic        en;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic        tx_done;

    logic [15:0] brg2;
    logic        en2;
    logic [7:0]  fifo_data2;
    logic        fifo_empty2;
    logic        fifo_rd_en2;
    logic        tx2;
    logic        busy2;
    logic        tx_done2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] fmem [0:63];
    int push_cnt = 0;
    int pop_cnt = 0;

    uart_tx #(.D_W(8), .B_TICK(16), .SB_TICK(16)) dut (
        .clk(clk), .rst(rst), .brg(brg), .en(en),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    uart_tx #(.D_W(8), .B_TICK(16), .SB_TICK(32)) dut2 (
        .clk(clk), .rst(rst), .brg(brg2), .en(en2),
        .fifo_data(fifo_data2), .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
        .tx(tx2), .busy(busy2), .tx_done(tx_done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: read data appears the cycle after the pop strobe.
    assign fifo_empty = (push_cnt == pop_cnt);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= fmem[pop_cnt % 64];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] brg;
        logic [7:0]  data;
        int          bt;
        int          flen;
        logic [9:0]  line;
        int          chg_at;
    } vec_t;

    vec_t vt [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[push_cnt % 64] = b;
        push_cnt = push_cnt + 1;
    endtask

    task automatic wait_pop(output int t);
        int n = 0;
        while (!fifo_rd_en && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("pop_seen", {31'd0, fifo_rd_en}, 32'd1);
        t = cyc;
    endtask

    task automatic wait_fall(input int t_pop, output int t_fall);
        int n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        t_fall = cyc;
        chk("fall_latency", t_fall - t_pop, 32'd2);
    endtask

    // Applies one frame and checks each bit twice (mid-bit and last cycle of
    // the bit), then the tx_done / busy timing at the frame end.
    task automatic run_frame(input string nm, input logic [7:0] b, input logic do_push,
                             input int bt, input int flen, input logic [9:0] line,
                             input int chg_at);
        int t_pop, t_fall;
        if (do_push) begin
            push(b);
            #1;
        end
        wait_pop(t_pop);
        wait_fall(t_pop, t_fall);
        for (int i = 0; i <= flen; i++) begin
            if (i > 0) @(negedge clk);
            if (i == chg_at) brg = 16'd0;
            if (i < flen && (i % bt == bt / 2 || i % bt == bt - 1))
                chk($sformatf("%s_bit%0d_off%0d", nm, i / bt, i), {31'd0, tx}, {31'd0, line[i / bt]});
            if (i == flen / 2)
                chk($sformatf("%s_busy_mid", nm), {31'd0, busy}, 32'd1);
            if (i == flen - 1)
                chk($sformatf("%s_done_early", nm), {31'd0, tx_done}, 32'd0);
            if (i == flen) begin
                chk($sformatf("%s_done", nm), {31'd0, tx_done}, 32'd1);
                chk($sformatf("%s_busy_end", nm), {31'd0, busy}, 32'd0);
                chk($sformatf("%s_tx_end", nm), {31'd0, tx}, 32'd1);
            end
        end
    endtask

    initial begin
        int t_pop, t_fall, base, n;
        logic bad;
        logic [9:0] line2;

        vt[0] = '{brg: 16'd0, data: 8'hA5, bt: 16, flen: 160, line: 10'b11_0100_1010, chg_at: -1};
        vt[1] = '{brg: 16'd3, data: 8'h3C, bt: 64, flen: 640, line: 10'b10_0111_1000, chg_at: 300};
        vt[2] = '{brg: 16'd1, data: 8'h5A, bt: 32, flen: 320, line: 10'b10_1011_0100, chg_at: -1};

        rst = 1'b0; en = 1'b0; brg = 16'd0;
        brg2 = 16'd0; en2 = 1'b1; fifo_data2 = 8'h55; fifo_empty2 = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rst = 1'b1;
        en  = 1'b1;

        // Empty FIFO: no pop, line stays high.
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        chk("empty_idle", {31'd0, bad}, 32'd0);
        chk("empty_pops", pop_cnt, 32'd0);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            brg = vt[k].brg;
            run_frame($sformatf("vec%0d", k), vt[k].data, 1'b1, vt[k].bt, vt[k].flen,
                      vt[k].line, vt[k].chg_at);
            repeat (5) @(negedge clk);
        end

        // Back-to-back: second pop lands on the tx_done cycle.
        brg  = 16'd0;
        base = pop_cnt;
        push(8'h00);
        push(8'hFF);
        #1;
        run_frame("b2b0", 8'h00, 1'b0, 16, 160, 10'b10_0000_0000, -1);
        chk("b2b_pop_on_done", {31'd0, fifo_rd_en}, 32'd1);
        run_frame("b2b1", 8'hFF, 1'b0, 16, 160, 10'b11_1111_1110, -1);
        repeat (20) @(negedge clk);
        chk("b2b_pops", pop_cnt - base, 32'd2);

        // Enable dropped mid-frame with data queued.
        base = pop_cnt;
        push(8'h81);
        push(8'h7E);
        #1;
        wait_pop(t_pop);
        repeat (50) @(negedge clk);
        en = 1'b0;
        n = 0;
        while (!tx_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("en_frame_done", {31'd0, tx_done}, 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        chk("en_low_no_pop", {31'd0, bad}, 32'd0);
        chk("en_low_pops", pop_cnt - base, 32'd1);
        en = 1'b1;
        #1;
        run_frame("en_resume", 8'h7E, 1'b0, 16, 160, 10'b10_1111_1100, -1);

        // Asynchronous reset during DATA bit 3.
        repeat (5) @(negedge clk);
        base = pop_cnt;
        push(8'hC3);
        push(8'h99);
        #1;
        wait_pop(t_pop);
        wait_fall(t_pop, t_fall);
        repeat (72) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_tx", {31'd0, tx}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, tx_done}, 32'd0);
        chk("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        repeat (3) @(negedge clk);
        chk("arst_pops", pop_cnt - base, 32'd1);
        rst = 1'b1;
        #1;
        run_frame("post_rst", 8'h99, 1'b0, 16, 160, 10'b11_0011_0010, -1);

        // Two stop bits on the second instance: 0x55, 176-cycle frame.
        repeat (5) @(negedge clk);
        line2 = 10'b10_1010_1010;
        fifo_empty2 = 1'b0;
        #1;
        chk("sb2_rd_en", {31'd0, fifo_rd_en2}, 32'd1);
        t_pop = cyc;
        @(negedge clk);
        fifo_empty2 = 1'b1;
        n = 0;
        while (tx2 !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        t_fall = cyc;
        chk("sb2_fall_latency", t_fall - t_pop, 32'd2);
        bad = 1'b0;
        for (int i = 0; i <= 176; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 144 && i % 16 == 8)
                chk($sformatf("sb2_bit%0d", i / 16), {31'd0, tx2}, {31'd0, line2[i / 16]});
            if (i >= 144 && i < 176 && tx2 !== 1'b1) bad = 1'b1;
            if (i == 175) begin
                chk("sb2_done_early", {31'd0, tx_done2}, 32'd0);
                chk("sb2_busy_late", {31'd0, busy2}, 32'd1);
            end
            if (i == 176) begin
                chk("sb2_done", {31'd0, tx_done2}, 32'd1);
                chk("sb2_busy_end", {31'd0, busy2}, 32'd0);
            end
        end
        chk("sb2_stop_high", {31'd0, bad}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage directly downstream of the transmit-channel FIFO in `uart_top`. It pops bytes from the TX FIFO, generates its own oversampling baud tick from a 16-bit divisor, and shifts each byte out as an asynchronous 8N1-style frame: start bit, LSB-first data, then a stop period. It drives the `tx` pin and exposes busy/done status to the control logic.

## Interface
- `D_W`, 8: data bits per frame.
- `B_TICK`, 16: baud ticks per start/data bit (oversampling factor).
- `SB_TICK`, 16: baud ticks in the stop period; 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- `clk`  in  1  single system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `brg`  in  16  baud divisor; one baud tick every `brg+1` clk cycles.
- `en`  in  1  transmit enable; gates new FIFO pops only.
- `fifo_data`  in  D_W  TX FIFO `data_out`.
- `fifo_empty`  in  1  TX FIFO `empty`.
- `fifo_rd_en`  out  1  TX FIFO `rd_en`; one-cycle pop strobe.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse at frame completion.

## Operation
- FIFO contract: the popped word is valid on `fifo_data` in the cycle after `fifo_rd_en`.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE: `fifo_rd_en = en & ~fifo_empty`, combinational. If it is asserted, the next state is LOAD. The tick divider and tick counter are held at 0.
- LOAD: capture `fifo_data` into the shift register and latch `brg` into `brg_q`, then go to START. `brg` changes after LOAD have no effect on the current frame.
- Divider: counts 0..`brg_q` and produces `tick` on the cycle it equals `brg_q`, then wraps to 0. With `brg_q=0`, `tick` is asserted every cycle.
- START: `tx=0`. After B_TICK ticks, clear the tick count and go to DATA with bit index 0.
- DATA: `tx` is shift-register bit 0. After each B_TICK ticks, shift right and increment the bit index. After D_W bits, go to STOP.
- STOP: `tx=1`. After SB_TICK ticks, go to IDLE and pulse `tx_done`.
- `tx` is registered and therefore glitch-free.
- `en` deasserted mid-frame: the frame completes normally, and no further pops occur.
- FIFO empty in IDLE: no pop, and `tx` stays high indefinitely.
- Counter widths: tick counter is `$clog2(max(B_TICK,SB_TICK))` bits; bit index is `$clog2(D_W)+1` bits. Neither counter may wrap within a state.

## Timing
- Reset values: `tx=1`, `busy=0`, `tx_done=0`, `fifo_rd_en=0`, state IDLE, all counters 0. Reset is asynchronous: asserting `rst=0` mid-frame forces `tx=1` immediately and drops the in-flight byte.
- Latency for a pop at cycle t:
  - LOAD occurs at t+1.
  - `tx` falls at the t+2 edge.
- Bit time: exactly `B_TICK*(brg+1)` cycles.
- Frame length: `((1+D_W)*B_TICK + SB_TICK)*(brg+1)` cycles measured from the `tx` fall.
- Frame end: `tx_done` and IDLE occur in the same cycle. `fifo_rd_en` may assert in that cycle.
- Back-to-back frames: the minimum gap between the end of one stop period and the next start edge is 2 cycles.
- `busy` rises with LOAD and falls with the return to IDLE.

## Test plan
- Single byte, defaults, `brg=0`: push 0xA5 →
  - `tx` emits 0, 1,0,1,0,0,1,0,1, 1, each bit for 16 cycles.
  - `tx` falls 2 cycles after `fifo_rd_en`.
  - `tx_done` pulses 160 cycles after the fall.
- Divisor `brg=3`: send 0x3C → each bit lasts 64 cycles and the frame lasts 640 cycles. Changing `brg` to 0 mid-frame does not alter the frame.
- Back-to-back: push 0x00, 0xFF → exactly 2 pops, the second pop on the `tx_done` cycle, 2 idle-high cycles between frames, and both bytes decoded correctly.
- Empty/enable:
  - FIFO empty → `fifo_rd_en` never asserts and `tx` stays 1.
  - Drop `en` mid-frame with data queued → the current frame completes and no further pop occurs until `en=1`.
- Reset mid-frame: assert `rst=0` during DATA bit 3 → `tx=1`, `busy=0`, `tx_done=0` asynchronously. After release, the next queued byte transmits cleanly.
- Two stop bits, `SB_TICK=32`, `brg=0`: send 0x55 → the stop period is 32 cycles and the frame is 176 cycles.
